// File: rtl/pong_pkg.sv
// Shared types and defaults for the Pong round controller.
// Consumers: pong_round_ctrl, pong_serve_timer.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    PLAY       = 3'd2,
    POINT      = 3'd3,
    OVER       = 3'd4
  } state_t;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  localparam int WIN_SCORE_DEF   = 7;
  localparam int SCORE_W_DEF     = 4;
  localparam int SERVE_DELAY_DEF = 60;
  localparam int DELAY_W_DEF     = 8;

endpackage

// File: rtl/pong_serve_timer.sv
// Serve hold-off down-counter; done fires on a qualified tick once the count is 0.
module pong_serve_timer
  import pong_pkg::*;
#(
  parameter int DELAY_W = DELAY_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [DELAY_W-1:0] load_val,
  input  logic               tick_en,
  output logic               done
);

  logic [DELAY_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick_en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = tick_en && (count == '0);

endmodule

// File: rtl/pong_round_ctrl.sv
// Pong match sequencer: serve hold-off, scoring, winner detection and pause.
// Optional macro PONG_DEUCE_EN: win needs a two-point lead (saturated score forces a result).
module pong_round_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = WIN_SCORE_DEF,
  parameter int SCORE_W     = SCORE_W_DEF,
  parameter int SERVE_DELAY = SERVE_DELAY_DEF,
  parameter int DELAY_W     = DELAY_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               tick,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               ball_hold,
  output logic               serve,
  output logic               serve_dir,
  output logic               game_over,
  output logic               winner
);

  localparam logic [SCORE_W-1:0] WIN_VAL   = WIN_SCORE[SCORE_W-1:0];
  localparam logic [DELAY_W-1:0] DELAY_VAL = SERVE_DELAY[DELAY_W-1:0];

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == '1) ? s : s + 1'b1;
  endfunction

  state_t             state, state_n;
  logic [SCORE_W-1:0] score_left_n, score_right_n;
  logic               ball_hold_n, serve_n, serve_dir_n, game_over_n, winner_n;
  logic               load, tick_en, timer_done;
  logic               win, win_side;

  pong_serve_timer #(.DELAY_W(DELAY_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .load_val (DELAY_VAL),
    .tick_en  (tick_en),
    .done     (timer_done)
  );

`ifdef PONG_DEUCE_EN
  logic left_sat, right_sat, left_lead2, right_lead2;

  assign left_sat    = (score_left == '1);
  assign right_sat   = (score_right == '1);
  // One extra bit so the +2 never wraps near saturation.
  assign left_lead2  = {1'b0, score_left}  >= ({1'b0, score_right} + {{(SCORE_W-1){1'b0}}, 2'd2});
  assign right_lead2 = {1'b0, score_right} >= ({1'b0, score_left}  + {{(SCORE_W-1){1'b0}}, 2'd2});

  always_comb begin
    win      = 1'b0;
    win_side = SIDE_LEFT;
    if (left_sat || right_sat) begin
      win      = 1'b1;
      win_side = (score_right > score_left) ? SIDE_RIGHT : SIDE_LEFT;
    end else if ((score_left >= WIN_VAL) && left_lead2) begin
      win      = 1'b1;
      win_side = SIDE_LEFT;
    end else if ((score_right >= WIN_VAL) && right_lead2) begin
      win      = 1'b1;
      win_side = SIDE_RIGHT;
    end
  end
`else
  assign win      = (score_left >= WIN_VAL) || (score_right >= WIN_VAL);
  assign win_side = (score_right >= WIN_VAL) ? SIDE_RIGHT : SIDE_LEFT;
`endif

  always_comb begin
    state_n       = state;
    score_left_n  = score_left;
    score_right_n = score_right;
    ball_hold_n   = ball_hold;
    serve_n       = 1'b0;
    serve_dir_n   = serve_dir;
    game_over_n   = game_over;
    winner_n      = winner;
    load          = 1'b0;
    tick_en       = 1'b0;
    case (state)
      IDLE: begin
        ball_hold_n = 1'b1;
        if (enable) begin
          state_n = SERVE_WAIT;
          load    = 1'b1;
        end
      end
      SERVE_WAIT: begin
        ball_hold_n = 1'b1;
        tick_en     = enable && tick;
        if (timer_done) begin
          state_n     = PLAY;
          serve_n     = 1'b1;
          ball_hold_n = 1'b0;
        end
      end
      PLAY: begin
        if (enable && (miss_left || miss_right)) begin
          state_n     = POINT;
          ball_hold_n = 1'b1;
          // A simultaneous double miss is a replay: nobody scores.
          if (miss_left && !miss_right) begin
            score_right_n = sat_inc(score_right);
            serve_dir_n   = SIDE_LEFT;
          end else if (miss_right && !miss_left) begin
            score_left_n = sat_inc(score_left);
            serve_dir_n  = SIDE_RIGHT;
          end
        end
      end
      POINT: begin
        if (enable) begin
          if (win) begin
            state_n     = OVER;
            game_over_n = 1'b1;
            winner_n    = win_side;
          end else begin
            state_n = SERVE_WAIT;
            load    = 1'b1;
          end
        end
      end
      OVER: begin
        ball_hold_n = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      score_left  <= '0;
      score_right <= '0;
      ball_hold   <= 1'b1;
      serve       <= 1'b0;
      serve_dir   <= SIDE_LEFT;
      game_over   <= 1'b0;
      winner      <= SIDE_LEFT;
    end else begin
      state       <= state_n;
      score_left  <= score_left_n;
      score_right <= score_right_n;
      ball_hold   <= ball_hold_n;
      serve       <= serve_n;
      serve_dir   <= serve_dir_n;
      game_over   <= game_over_n;
      winner      <= winner_n;
    end
  end

endmodule

// File: tb/tb_pong_round_ctrl.sv
// Directed bench for pong_round_ctrl (SERVE_DELAY=3; WIN_SCORE=3 when PONG_DEUCE_EN is set).
module tb_pong_round_ctrl;

`ifdef PONG_DEUCE_EN
  localparam int WIN = 3;
`else
  localparam int WIN = 7;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       tick = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic [3:0] score_left, score_right;
  logic       ball_hold, serve, serve_dir, game_over, winner;

  int total = 0;
  int bad = 0;

  pong_round_ctrl #(
    .WIN_SCORE   (WIN),
    .SCORE_W     (4),
    .SERVE_DELAY (3),
    .DELAY_W     (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .tick        (tick),
    .miss_left   (miss_left),
    .miss_right  (miss_right),
    .score_left  (score_left),
    .score_right (score_right),
    .ball_hold   (ball_hold),
    .serve       (serve),
    .serve_dir   (serve_dir),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic do_miss(input logic l, input logic r);
    miss_left  = l;
    miss_right = r;
    cyc();
    miss_left  = 1'b0;
    miss_right = 1'b0;
  endtask

  // From SERVE_WAIT with a freshly loaded timer (3): serve follows the 4th tick.
  task automatic run_serve(input int exp_dir);
    chk("hold_before_serve", ball_hold, 1);
    for (int k = 0; k < 4; k++) begin
      pulse_tick();
      if (k < 3) begin
        chk("no_early_serve", serve, 0);
        cyc();
      end else begin
        chk("serve_pulse", serve, 1);
        chk("serve_hold", ball_hold, 0);
        chk("serve_dir", serve_dir, exp_dir);
        cyc();
        chk("serve_one_cycle", serve, 0);
      end
    end
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b1;
    cyc();
    cyc();
    chk("rst_score_l", score_left, 0);
    chk("rst_score_r", score_right, 0);
    chk("rst_hold", ball_hold, 1);
    chk("rst_serve", serve, 0);
    chk("rst_dir", serve_dir, 0);
    chk("rst_over", game_over, 0);
    chk("rst_winner", winner, 0);
    reset = 1'b1;
    cyc();                        // IDLE -> SERVE_WAIT
    run_serve(0);

`ifdef PONG_DEUCE_EN
    for (int i = 0; i < 3; i++) begin
      do_miss(1'b0, 1'b1);
      cyc();
      run_serve(1);
      do_miss(1'b1, 1'b0);
      cyc();
      chk("deuce_no_over", game_over, 0);
      run_serve(0);
    end
    chk("deuce_l3", score_left, 3);
    chk("deuce_r3", score_right, 3);
    do_miss(1'b1, 1'b0);
    cyc();
    chk("lead1_no_over", game_over, 0);
    run_serve(0);
    do_miss(1'b1, 1'b0);
    chk("lead2_r", score_right, 5);
    cyc();
    chk("lead2_over", game_over, 1);
    chk("lead2_winner", winner, 1);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();                        // SERVE_WAIT again
    pulse_tick();
    reset = 1'b0;
    cyc();
    chk("midserve_rst_l", score_left, 0);
    chk("midserve_rst_r", score_right, 0);
    chk("midserve_rst_over", game_over, 0);
    reset = 1'b1;
    chk("midserve_rst_hold", ball_hold, 1);
`else
    // Point to left; next serve heads right.
    do_miss(1'b0, 1'b1);
    chk("pt_score_l", score_left, 1);
    chk("pt_score_r", score_right, 0);
    chk("pt_hold", ball_hold, 1);
    cyc();
    run_serve(1);

    // Double miss is a replay.
    do_miss(1'b1, 1'b1);
    chk("dbl_score_l", score_left, 1);
    chk("dbl_score_r", score_right, 0);
    cyc();
    run_serve(1);

    // Paused misses are dropped.
    enable = 1'b0;
    do_miss(1'b1, 1'b0);
    chk("pause_miss_r", score_right, 0);
    chk("pause_hold", ball_hold, 0);
    enable = 1'b1;

    // Pause during SERVE_WAIT with timer=2.
    do_miss(1'b1, 1'b0);
    chk("after_pause_miss_r", score_right, 1);
    cyc();
    pulse_tick();
    chk("pw_first_tick", serve, 0);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pulse_tick();
      chk("pw_paused_serve", serve, 0);
    end
    enable = 1'b1;
    pulse_tick();
    chk("pw_tick1", serve, 0);
    pulse_tick();
    chk("pw_tick2", serve, 0);
    pulse_tick();
    chk("pw_tick3_serve", serve, 1);
    chk("pw_dir", serve_dir, 0);
    cyc();

    // Right wins after reaching 7.
    for (int i = 2; i < 7; i++) begin
      do_miss(1'b1, 1'b0);
      chk("run_score_r", score_right, i);
      cyc();
      chk("run_no_over", game_over, 0);
      run_serve(0);
    end
    do_miss(1'b1, 1'b0);
    chk("win_score_r", score_right, 7);
    chk("win_over_n1", game_over, 0);
    cyc();
    chk("win_over_n2", game_over, 1);
    chk("win_winner", winner, 1);
    chk("win_hold", ball_hold, 1);
    for (int i = 0; i < 6; i++) begin
      enable = i[0];
      tick = 1'b1;
      do_miss(i[1], ~i[1]);
      tick = 1'b0;
      chk("over_score_l", score_left, 1);
      chk("over_score_r", score_right, 7);
      chk("over_flag", game_over, 1);
      chk("over_serve", serve, 0);
    end
    enable = 1'b1;
    reset = 1'b0;
    cyc();
    chk("over_rst_r", score_right, 0);
    chk("over_rst_over", game_over, 0);
    chk("over_rst_winner", winner, 0);
    reset = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
